// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_arbiter
// Purpose  : Write-port controller for the general-purpose register bank.
//            After reset it clears the bank through its single write port,
//            one register per cycle. It then shares the port between two
//            writeback requesters (A = ALU, B = memory/load) with round-robin
//            priority. Granted writes to register 0 are dropped because that
//            register is hardwired to zero. Granted writes to an unimplemented
//            register are dropped and raise a sticky error flag.
// Macro    : REGWR_INIT_CLEAR_EN - when defined, the post-reset clearing sweep
//            is built. When undefined, the block resets straight into normal
//            operation and init_busy is tied low.
// Ports    : clk               rising-edge clock
//            rst               asynchronous, active-low reset
//            a_req/a_addr/a_data  requester A write request, address, data
//            a_gnt             requester A accepted this cycle (combinational)
//            b_req/b_addr/b_data  requester B write request, address, data
//            b_gnt             requester B accepted this cycle (combinational)
//            rf_en/rf_rd/rf_data  registered bank write enable/address/data
//            init_busy         clearing sweep in progress (no grants)
//            err_addr          sticky: an invalid address was granted
// Revision : 1.0 - initial release
// ============================================================================
module regbank_write_arbiter #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic          a_gnt,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          b_gnt,
   output logic          rf_en,
   output logic [AW-1:0] rf_rd,
   output logic [DW-1:0] rf_data,
   output logic          init_busy,
   output logic          err_addr
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

`ifdef REGWR_INIT_CLEAR_EN
   localparam state_t        RST_STATE = ST_INIT;
   localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);
`else
   localparam state_t        RST_STATE = ST_RUN;
`endif
   // One extra bit so the validity compare also works when NREG == 2**AW.
   localparam logic [AW:0]   NREG_EXT  = (AW+1)'(NREG);

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;          // 0: A has priority, 1: B has priority
   logic          rf_en_q, rf_en_d;
   logic [AW-1:0] rf_rd_q, rf_rd_d;
   logic [DW-1:0] rf_data_q, rf_data_d;
   logic          err_q, err_d;
`ifdef REGWR_INIT_CLEAR_EN
   logic [AW-1:0] cnt_q, cnt_d;
`endif

   logic          run;
   logic          grant;
   logic [AW-1:0] gnt_addr;
   logic [DW-1:0] gnt_data;
   logic          addr_zero;
   logic          addr_bad;

   assign run = (state_q == ST_RUN);

   // A requester wins when the other is idle or when it holds priority.
   assign a_gnt = run & a_req & (~b_req | ~ptr_q);
   assign b_gnt = run & b_req & (~a_req |  ptr_q);
   assign grant = a_gnt | b_gnt;

   assign gnt_addr  = a_gnt ? a_addr : b_addr;
   assign gnt_data  = a_gnt ? a_data : b_data;
   assign addr_zero = (gnt_addr == '0);
   assign addr_bad  = ({1'b0, gnt_addr} >= NREG_EXT);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rf_en_d   = 1'b0;
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      err_d     = err_q;
`ifdef REGWR_INIT_CLEAR_EN
      cnt_d     = cnt_q;
`endif
      if (state_q == ST_INIT) begin
`ifdef REGWR_INIT_CLEAR_EN
         rf_en_d   = 1'b1;
         rf_rd_d   = cnt_q;
         rf_data_d = '0;
         cnt_d     = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
         end
`else
         state_d = ST_RUN;
`endif
      end else if (grant) begin
         // Priority always passes to the other requester, even after a
         // lone-requester grant.
         ptr_d     = a_gnt;
         rf_rd_d   = gnt_addr;
         rf_data_d = gnt_data;
         rf_en_d   = ~addr_zero & ~addr_bad;
         if (addr_bad) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RST_STATE;
         ptr_q     <= 1'b0;
         rf_en_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rf_en_q   <= rf_en_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
         err_q     <= err_d;
      end
   end

`ifdef REGWR_INIT_CLEAR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign init_busy = (state_q == ST_INIT);
`else
   assign init_busy = 1'b0;
`endif

   assign rf_en    = rf_en_q;
   assign rf_rd    = rf_rd_q;
   assign rf_data  = rf_data_q;
   assign err_addr = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_write_arbiter
// Purpose  : Self-checking bench for regbank_write_arbiter. A behavioural
//            model tracks priority and the expected bank-port contents. It is
//            driven by directed steps and by random requesters that hold each
//            request until it is granted. The clearing sweep is checked when
//            REGWR_INIT_CLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, b_req;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_gnt, b_gnt;
   logic          rf_en;
   logic [AW-1:0] rf_rd;
   logic [DW-1:0] rf_data;
   logic          init_busy;
   logic          err_addr;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int            m_prio;    // 0: A next in line, 1: B next in line
   logic          m_en;
   logic [AW-1:0] m_rd;
   logic [DW-1:0] m_data;
   logic          m_known;   // rf_rd/rf_data are only defined after a real write
   logic          m_err;
   logic          last_a, last_b;   // model grants of the latest step
   logic          obs_a, obs_b;     // DUT grants seen in the latest step

   regbank_write_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (a_req),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .a_gnt     (a_gnt),
      .b_req     (b_req),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .b_gnt     (b_gnt),
      .rf_en     (rf_en),
      .rf_rd     (rf_rd),
      .rf_data   (rf_data),
      .init_busy (init_busy),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prio  = 0;
      m_en    = 1'b0;
      m_rd    = '0;
      m_data  = '0;
      m_known = 1'b1;
      m_err   = 1'b0;
      last_a  = 1'b0;
      last_b  = 1'b0;
   endtask

   task automatic check_reset_vals(input logic busy_exp);
      chk("rst_rf_en",   64'(rf_en),     64'd0);
      chk("rst_rf_rd",   64'(rf_rd),     64'd0);
      chk("rst_rf_data", 64'(rf_data),   64'd0);
      chk("rst_err",     64'(err_addr),  64'd0);
      chk("rst_busy",    64'(init_busy), 64'(busy_exp));
   endtask

   // Release reset just after a rising edge so the next edge is edge 1.
   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One RUN-mode cycle: inputs are already set. Grants are checked at the
   // falling edge, the registered bank port one step after the rising edge.
   task automatic step();
      logic          ea, eb;
      logic [AW-1:0] ad;
      logic [DW-1:0] dt;
      @(negedge clk);
      ea = a_req && (!b_req || m_prio == 0);
      eb = b_req && !ea;
      obs_a = a_gnt;
      obs_b = b_gnt;
      chk("a_gnt", 64'(a_gnt), 64'(ea));
      chk("b_gnt", 64'(b_gnt), 64'(eb));
      last_a = ea;
      last_b = eb;
      if (ea || eb) begin
         ad     = ea ? a_addr : b_addr;
         dt     = ea ? a_data : b_data;
         m_prio = ea ? 1 : 0;
         if (ad == 0) begin
            m_en    = 1'b0;
            m_known = 1'b0;
         end else if (int'(ad) >= NREG) begin
            m_en    = 1'b0;
            m_known = 1'b0;
            m_err   = 1'b1;
         end else begin
            m_en    = 1'b1;
            m_rd    = ad;
            m_data  = dt;
            m_known = 1'b1;
         end
      end else begin
         m_en = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rf_en", 64'(rf_en), 64'(m_en));
      if (m_known) begin
         chk("rf_rd",   64'(rf_rd),   64'(m_rd));
         chk("rf_data", 64'(rf_data), 64'(m_data));
      end
      chk("err_addr",  64'(err_addr),  64'(m_err));
      chk("init_busy", 64'(init_busy), 64'd0);
   endtask

   // Random requesters: a request stays stable until granted, then a new
   // one may be drawn.
   task automatic rand_cycles(input int n, input int maxaddr);
      for (int i = 0; i < n; i++) begin
         if (!a_req || last_a) begin
            a_req  = ($urandom_range(0, 99) < 70);
            a_addr = AW'($urandom_range(0, maxaddr));
            a_data = $urandom;
         end
         if (!b_req || last_b) begin
            b_req  = ($urandom_range(0, 99) < 70);
            b_addr = AW'($urandom_range(0, maxaddr));
            b_data = $urandom;
         end
         step();
      end
   endtask

`ifdef REGWR_INIT_CLEAR_EN
   // Reset has just been released; edges 1..NREG each register one clear.
   task automatic do_sweep();
      for (int k = 0; k < NREG; k++) begin
         @(posedge clk);
         #1;
         chk("sweep_en",   64'(rf_en),     64'd1);
         chk("sweep_rd",   64'(rf_rd),     64'(k));
         chk("sweep_data", 64'(rf_data),   64'd0);
         chk("sweep_busy", 64'(init_busy), 64'(k < NREG - 1));
         if (k < NREG - 1) begin
            chk("sweep_a_gnt", 64'(a_gnt), 64'(0));
            chk("sweep_b_gnt", 64'(b_gnt), 64'(0));
         end
      end
      a_req   = 1'b0;
      b_req   = 1'b0;
      m_rd    = AW'(NREG - 1);
      m_data  = '0;
      m_known = 1'b1;
   endtask
`endif

   initial begin
      rst    = 1'b0;
      a_req  = 1'b0;
      b_req  = 1'b0;
      a_addr = '0;
      b_addr = '0;
      a_data = '0;
      b_data = '0;
      model_reset();
      #3;
`ifdef REGWR_INIT_CLEAR_EN
      check_reset_vals(1'b1);
      release_reset();
      // Requests during the sweep must not be granted.
      a_req  = 1'b1;
      b_req  = 1'b1;
      a_addr = 5'd9;
      b_addr = 5'd10;
      do_sweep();
      step();                      // sweep over: idle, rf_en low
`else
      check_reset_vals(1'b0);
      release_reset();
      a_req  = 1'b1;
      a_addr = 5'd7;
      a_data = 32'h0BADF00D;
      #1;
      chk("first_cycle_busy",  64'(init_busy), 64'd0);
      chk("first_cycle_a_gnt", 64'(a_gnt),     64'd1);
      step();
      a_req = 1'b0;
      step();
`endif

      // Lone A write
      a_req  = 1'b1;
      a_addr = 5'd5;
      a_data = 32'hDEADBEEF;
      step();
      chk("lone_a_rd",   64'(rf_rd),   64'd5);
      chk("lone_a_data", 64'(rf_data), 64'hDEADBEEF);
      a_req = 1'b0;

      // Lone B write hands priority back to A
      b_req  = 1'b1;
      b_addr = 5'd3;
      b_data = 32'h12345678;
      step();
      b_req = 1'b0;

      // Both continuously requesting: A, B, A, B
      a_req  = 1'b1;
      a_addr = 5'd1;
      a_data = 32'hA0000001;
      b_req  = 1'b1;
      b_addr = 5'd2;
      b_data = 32'hB0000002;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_order_a", 64'(obs_a), 64'(i % 2 == 0));
         chk("rr_order_b", 64'(obs_b), 64'(i % 2 == 1));
         if (obs_a) begin
            a_addr = a_addr + 5'd2;
            a_data = a_data + 32'd1;
         end
         if (obs_b) begin
            b_addr = b_addr + 5'd2;
            b_data = b_data + 32'd1;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      step();

      // Write to register 0 is granted but dropped
      b_req  = 1'b1;
      b_addr = 5'd0;
      b_data = 32'hFFFFFFFF;
      step();
      b_req = 1'b0;

      rand_cycles(200, NREG - 1);
      a_req = 1'b0;
      b_req = 1'b0;
      step();

      // Out-of-range write: granted, dropped, sticky error
      b_req  = 1'b1;
      b_addr = 5'd20;
      b_data = 32'h55AA55AA;
      step();
      b_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
      end
      chk("err_sticky", 64'(err_addr), 64'd1);

      rand_cycles(200, (1 << AW) - 1);

      // Asynchronous reset in the middle of operation
      a_req = 1'b0;
      b_req = 1'b0;
`ifdef REGWR_INIT_CLEAR_EN
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals(1'b1);
      release_reset();
      model_reset();
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
      end
      #1;
      chk("mid_sweep_rd", 64'(rf_rd), 64'd7);
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals(1'b1);
      release_reset();
      model_reset();
      do_sweep();
      step();
`else
      a_req  = 1'b1;
      a_addr = 5'd4;
      a_data = 32'hCAFE0004;
      #2;
      rst = 1'b0;
      #1;
      check_reset_vals(1'b0);
      release_reset();
      model_reset();
      step();
      a_req = 1'b0;
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Write-port controller for the 16-entry general-purpose register bank. After reset it sequences a clearing sweep through the bank's single write port, then shares that port between two writeback requesters (A: ALU writeback, B: memory/load writeback) using round-robin arbitration. Its registered outputs drive the bank's `en` / `rd` / `data` inputs directly.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, register address width
- `NREG`, 16, number of implemented registers; addresses `>= NREG` are invalid

Ports:
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-low
- `a_req`  in  1  requester A write request
- `a_addr`  in  AW  requester A destination register
- `a_data`  in  DW  requester A write data
- `a_gnt`  out  1  A accepted this cycle (combinational)
- `b_req`, `b_addr`, `b_data`, `b_gnt`: same as A, for requester B
- `rf_en`  out  1  bank write enable (registered)
- `rf_rd`  out  AW  bank write address (registered)
- `rf_data`  out  DW  bank write data (registered)
- `init_busy`  out  1  clearing sweep in progress; no grants
- `err_addr`  out  1  sticky; set when an invalid address is granted

## Operation
- States are `INIT` (clearing sweep) and `RUN`.
- `INIT`:
  - Counter `cnt` runs 0..NREG-1.
  - Each cycle issues one write: `rf_en`=1, `rf_rd`=`cnt`, `rf_data`=0.
  - At `cnt`=NREG-1 the FSM moves to `RUN` and `init_busy` drops.
  - `a_gnt` and `b_gnt` are held at 0 throughout.
- `RUN`:
  - `gnt_X` = `req_X` AND (other requester not requesting OR priority pointer = X).
  - At most one grant per cycle.
  - A granted request is consumed. An ungranted request must be held stable by its requester until granted.
- Priority pointer:
  - After a grant to X, priority passes to the other requester.
  - A lone requester is granted regardless of the pointer, and the pointer still flips.
- Address filter (applies to granted writes only):
  - Address 0: granted, but `rf_en`=0. Register 0 is hardwired to zero.
  - Address `>= NREG`: granted, `rf_en`=0, `err_addr` set until reset.
  - Otherwise: `rf_en`=1 with the granted address and data.
- No grant in a cycle: `rf_en`=0. `rf_rd` and `rf_data` hold their previous values.

## Timing
- Reset values (asserted asynchronously):
  - `rf_en`=0, `rf_rd`=0, `rf_data`=0, `err_addr`=0
  - `init_busy`=1, state=`INIT`, `cnt`=0, pointer=A
- Sweep:
  - Edge k after reset release (k=1..NREG) registers the write of register k-1.
  - `init_busy` is low after edge NREG; first grant is possible in the following cycle.
- Write latency: the grant in cycle n appears on `rf_*` after edge n+1; the bank commits it at edge n+2.
- Throughput: one write per cycle. With both requesters continuously active, grants alternate A, B, A, …
- Reset asserted mid-sweep or mid-`RUN`: everything returns to reset values; the sweep restarts from register 0.

## Configuration
- `REGWR_INIT_CLEAR_EN` defined:
  - `INIT` sweep is present as described above.
- `REGWR_INIT_CLEAR_EN` undefined:
  - No sweep; the FSM resets directly into `RUN`.
  - `init_busy` is tied to 0.
  - Grants are possible in the first cycle after reset release.
  - The `cnt` logic is not compiled.

## Test plan
- Release reset, no requests (macro on) -> `rf_en`=1 for 16 consecutive cycles, `rf_rd`=0..15 in order, `rf_data`=0; then `init_busy`=0 and `rf_en`=0.
- `a_req` only, `a_addr`=5, `a_data`=0xDEADBEEF -> `a_gnt`=1 the same cycle; next cycle `rf_en`=1, `rf_rd`=5, `rf_data`=0xDEADBEEF.
- `a_req` and `b_req` both held for 4 cycles, pointer=A -> grant order A, B, A, B; `rf_rd` follows the corresponding addresses.
- `b_req`, `b_addr`=0 -> `b_gnt`=1, `rf_en`=0. Then `b_addr`=20 -> `b_gnt`=1, `rf_en`=0, `err_addr`=1 and it stays 1.
- Assert `rst` at sweep register 7 -> outputs return to reset values immediately; after release, the sweep restarts at `rf_rd`=0.
- Macro undefined, `a_req` in the first cycle after reset release -> `a_gnt`=1, `init_busy`=0.
